// File: rtl/rr_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_sel_arbiter
// Round-robin arbiter that drives the select of a 4:1 data mux. It presents
// the selected channel downstream under a valid/ready handshake and acks the
// winning source on transfer. A burst limit lets one owner keep the grant for
// up to BURST consecutive transfers before the grant rotates.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   per-channel request (channel i data valid on mux input i)
//   ack[3:0]   one-hot transfer ack, combinational from the handshake
//   sel[1:0]   registered mux select, stable while out_valid=1
//   out_valid  registered, mux output valid downstream
//   out_ready  downstream accepts when out_valid & out_ready
//   busy       registered, 1 while in GRANT (same as out_valid)
// ---------------------------------------------------------------------------
module rr_mux_sel_arbiter #(
    parameter int BURST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [1:0] sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    // Set once any channel has been granted since reset. Before that there is
    // no owner to extend, so the first grant always comes from the rotating
    // search (which starts at channel 0 because last resets to 3).
    logic       own_q, own_d;

    logic       xfer;
    logic [1:0] rr_win;
    logic       rr_hit;

    assign out_valid = (state_q == GRANT);
    assign busy      = out_valid;
    assign sel       = sel_q;
    assign xfer      = out_valid & out_ready;
    assign ack       = xfer ? (4'b0001 << sel_q) : 4'b0000;

    // Rotating priority search: last+1 first, wrapping back to last itself.
    always_comb begin
        rr_win = last_q;
        rr_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_hit && req[last_q + 2'(k)]) begin
                rr_win = last_q + 2'(k);
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    own_d   = 1'b1;
                    if (own_q && (cnt_q < BURST_L) && req[last_q]) begin
                        sel_d = last_q;            // owner keeps the burst
                    end else begin
                        sel_d = rr_win;
                        cnt_d = 4'd0;              // new burst, even on wrap-back
                    end
                    last_d = sel_d;
                end
            end
            GRANT: begin
                if (xfer) begin
                    state_d = IDLE;
                    if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                end else if (!req[sel_q]) begin
                    state_d = IDLE;                // withdrawn, no ack
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
module tb_rr_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req1 = 4'b0, req2 = 4'b0;
    logic       rdy1 = 1'b0, rdy2 = 1'b0;
    logic [3:0] ack1, ack2;
    logic [1:0] sel1, sel2;
    logic       vld1, vld2, busy1, busy2;

    int total = 0;
    int bad   = 0;

    logic [3:0] q1[$];
    logic [3:0] q2[$];

    always #5 clk = ~clk;

    rr_mux_sel_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ack(ack1), .sel(sel1),
        .out_valid(vld1), .out_ready(rdy1), .busy(busy1)
    );

    rr_mux_sel_arbiter #(.BURST(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .ack(ack2), .sel(sel2),
        .out_valid(vld2), .out_ready(rdy2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every ack the DUT produces must match the next
    // expected ack pushed by the stimulus.
    always @(negedge clk) begin
        if (ack1 != 4'b0) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL mon1_unexpected act=%b exp=none @%0t", ack1, $time);
            end else chk("mon1_ack", 32'(ack1), 32'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (ack2 != 4'b0) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL mon2_unexpected act=%b exp=none @%0t", ack2, $time);
            end else chk("mon2_ack", 32'(ack2), 32'(q2.pop_front()));
        end
    end

    logic [1:0] exp2_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] exp3_sel [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    initial begin
        // ---- reset state ----
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_valid", 32'(vld1), 0);
        chk("rst_sel",   32'(sel1), 0);
        chk("rst_busy",  32'(busy1), 0);
        chk("rst_ack",   32'(ack1), 0);

        // ---- 1: single request ----
        q1.push_back(4'b0001);
        req1 = 4'b0001; rdy1 = 1'b1;
        tick(1);
        chk("t1_sel",   32'(sel1), 0);
        chk("t1_valid", 32'(vld1), 1);
        chk("t1_ack",   32'(ack1), 32'h1);
        req1 = 4'b0000;
        tick(1);
        chk("t1_valid_off", 32'(vld1), 0);
        tick(2);

        // ---- 2: full contention, BURST=1 ----
        rst = 1'b1; tick(1); rst = 1'b0;
        foreach (exp2_sel[i]) q1.push_back(4'b0001 << exp2_sel[i]);
        req1 = 4'b1111; rdy1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t2_sel",   32'(sel1), 32'(exp2_sel[i]));
            chk("t2_valid", 32'(vld1), 1);
            if (i == 5) req1 = 4'b0000;
            tick(1);
            chk("t2_bubble", 32'(vld1), 0);
        end
        tick(2);

        // ---- 3: burst limit, BURST=2 ----
        rst = 1'b1; tick(1); rst = 1'b0;
        foreach (exp3_sel[i]) q2.push_back(4'b0001 << exp3_sel[i]);
        req2 = 4'b0011; rdy2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t3_sel",   32'(sel2), 32'(exp3_sel[i]));
            chk("t3_valid", 32'(vld2), 1);
            if (i == 5) req2 = 4'b0001;
            tick(1);
            chk("t3_bubble", 32'(vld2), 0);
        end
        for (int j = 0; j < 4; j++) q2.push_back(4'b0001);
        for (int j = 0; j < 4; j++) begin
            tick(1);
            chk("t3_solo_sel",   32'(sel2), 0);
            chk("t3_solo_valid", 32'(vld2), 1);
            if (j == 3) req2 = 4'b0000;
            tick(1);
            chk("t3_solo_bubble", 32'(vld2), 0);
        end
        tick(2);

        // ---- 4: backpressure ----
        rst = 1'b1; tick(1); rst = 1'b0;
        req1 = 4'b0100; rdy1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t4_hold_sel",   32'(sel1), 2);
            chk("t4_hold_valid", 32'(vld1), 1);
            chk("t4_hold_ack",   32'(ack1), 0);
        end
        tick(1);
        q1.push_back(4'b0100);
        rdy1 = 1'b1; req1 = 4'b0000;
        #1;
        chk("t4_ack", 32'(ack1), 32'h4);
        tick(1);
        chk("t4_valid_off", 32'(vld1), 0);
        tick(2);

        // ---- 5: withdraw ----
        rst = 1'b1; tick(1); rst = 1'b0;
        req1 = 4'b0010; rdy1 = 1'b0;
        tick(1);
        chk("t5_sel1",   32'(sel1), 1);
        chk("t5_valid1", 32'(vld1), 1);
        req1 = 4'b1000;
        tick(1);
        chk("t5_withdraw_valid", 32'(vld1), 0);
        chk("t5_withdraw_ack",   32'(ack1), 0);
        tick(1);
        chk("t5_sel3",   32'(sel1), 3);
        chk("t5_valid3", 32'(vld1), 1);

        // ---- 6: reset mid-GRANT ----
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_valid", 32'(vld1), 0);
        chk("t6_sel",   32'(sel1), 0);
        chk("t6_busy",  32'(busy1), 0);
        req1 = 4'b1111;
        tick(1);
        chk("t6_first_sel", 32'(sel1), 0);
        chk("t6_first_vld", 32'(vld1), 1);
        q1.push_back(4'b0001);
        rdy1 = 1'b1; req1 = 4'b0000;
        tick(1);
        chk("t6_valid_off", 32'(vld1), 0);
        tick(3);

        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
